// File: rtl/pipe_ctrl_pkg.sv
// Types and helpers for pipe_ctrl: FSM state type built on the shared
// encodings, stall patterns per request source, and the stall priority encoder.
`include "defines.v"

package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      S_RUN   = `ST_RUN,
      S_PEND  = `ST_PEND,
      S_FLUSH = `ST_FLUSH
   } state_t;

   // Each pattern holds the requesting stage and every stage upstream of it.
   localparam logic [`STALL_BUS] STALL_NONE = 6'b000000;
   localparam logic [`STALL_BUS] STALL_IF   = 6'b000011;
   localparam logic [`STALL_BUS] STALL_ID   = 6'b000111;
   localparam logic [`STALL_BUS] STALL_EXE  = 6'b001111;
   localparam logic [`STALL_BUS] STALL_MEM  = 6'b011111;
   // An exception freezes everything up to MEM while the redirect is prepared.
   localparam logic [`STALL_BUS] STALL_EXC  = STALL_MEM;

   // Highest-priority request wins: the deepest stage stalls the most.
   function automatic logic [`STALL_BUS] stall_from_req(
      input logic req_if,
      input logic req_id,
      input logic req_exe,
      input logic req_mem
   );
      logic [`STALL_BUS] v_stall;
      v_stall = STALL_NONE;
      if (req_mem)
         v_stall = STALL_MEM;
      else if (req_exe)
         v_stall = STALL_EXE;
      else if (req_id)
         v_stall = STALL_ID;
      else if (req_if)
         v_stall = STALL_IF;
      return v_stall;
   endfunction

endpackage

// File: rtl/defines.v
// Shared constants for the pipeline controller: stall bus layout, stop and
// flush levels, reset PC, instruction address bus and FSM state encodings.
`ifndef PIPE_CTRL_DEFINES_V
`define PIPE_CTRL_DEFINES_V

`define STALL_BUS      5:0
`define STOP           1'b1
`define NOSTOP         1'b0
`define FLUSH          1'b1
`define NOFLUSH        1'b0
`define PC_INIT        32'hBFC00000
`define INST_ADDR_BUS  31:0

`define ST_RUN         2'b00
`define ST_PEND        2'b01
`define ST_FLUSH       2'b10

`endif

// File: rtl/pipe_perf_cnt.sv
// Performance counters for pipe_ctrl: cycles with the PC held and number of
// flush cycles. Both counters wrap silently. Only instantiated when
// PIPE_PERF_CNT_EN is defined.
module pipe_perf_cnt (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst_n,
   input  logic        stall_pc,
   input  logic        flush,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   logic [31:0] r_stall_cycles;
   logic [15:0] r_flush_count;

   // Count PC-stall cycles and flush cycles, cleared by reset.
   always_ff @(posedge cpu_clk_50M) begin
      if (!cpu_rst_n) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (stall_pc)
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (flush)
            r_flush_count <= r_flush_count + 16'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: builds the per-stage stall vector from the stage
// requests and sequences exception/eret flushes (RUN -> [PEND] -> FLUSH -> RUN).
// A flush is deferred while an instruction or data bus transaction is in
// flight so that bus transactions are never aborted; the first exception wins.
// Optional build macro: PIPE_PERF_CNT_EN adds stall_cycles / flush_count.
`include "defines.v"

module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic                  cpu_clk_50M,
   input  logic                  cpu_rst_n,
   input  logic                  stallreq_if,
   input  logic                  stallreq_id,
   input  logic                  stallreq_exe,
   input  logic                  stallreq_mem,
   input  logic                  exc_valid,
   input  logic [`INST_ADDR_BUS] exc_target,
   output logic [`STALL_BUS]     stall,
   output logic                  flush,
   output logic [`INST_ADDR_BUS] flush_pc
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [15:0]           flush_count
`endif
);

   state_t                r_state;
   logic                  r_flush;
   logic [`INST_ADDR_BUS] r_flush_pc;
   logic [`INST_ADDR_BUS] r_target;

   logic                  w_bus_busy;
   logic [`STALL_BUS]     w_stall;

   // Either bus still has a transaction outstanding; flushing now would drop it.
   assign w_bus_busy = stallreq_if | stallreq_mem;

   // Stall vector: request priority in RUN, full freeze while an exception is
   // being taken or waits for the buses, released during the flush cycle.
   always_comb begin
      // NOTE: default assignment first so every path drives w_stall and no latch is inferred.
      w_stall = STALL_NONE;
      if (cpu_rst_n) begin
         case (r_state)
            S_RUN:   w_stall = exc_valid ? STALL_EXC
                                         : stall_from_req(stallreq_if, stallreq_id,
                                                          stallreq_exe, stallreq_mem);
            S_PEND:  w_stall = STALL_EXC;
            S_FLUSH: w_stall = STALL_NONE;
            default: w_stall = STALL_NONE;
         endcase
      end
   end

   // Exception FSM with registered flush and flush_pc outputs.
   always_ff @(posedge cpu_clk_50M) begin
      // NOTE: non-blocking assignments keep every register update on the same edge, race-free.
      if (!cpu_rst_n) begin
         r_state    <= S_RUN;
         r_flush    <= `NOFLUSH;
         r_flush_pc <= `PC_INIT;
         r_target   <= `PC_INIT;
      end else begin
         r_flush <= `NOFLUSH;
         case (r_state)
            S_RUN: begin
               if (exc_valid) begin
                  r_target <= exc_target;
                  if (w_bus_busy) begin
                     r_state <= S_PEND;
                  end else begin
                     r_state    <= S_FLUSH;
                     r_flush    <= `FLUSH;
                     r_flush_pc <= exc_target;
                  end
               end
            end
            S_PEND: begin
               // Later exceptions are ignored here: the latched target stands.
               if (!w_bus_busy) begin
                  r_state    <= S_FLUSH;
                  r_flush    <= `FLUSH;
                  r_flush_pc <= r_target;
               end
            end
            S_FLUSH: begin
               // Exactly one flush cycle; any exception seen now is dropped.
               r_state <= S_RUN;
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

   assign stall    = w_stall;
   assign flush    = r_flush;
   assign flush_pc = r_flush_pc;

`ifdef PIPE_PERF_CNT_EN
   pipe_perf_cnt u_perf_cnt (
      .cpu_clk_50M  (cpu_clk_50M),
      .cpu_rst_n    (cpu_rst_n),
      .stall_pc     (w_stall[0]),
      .flush        (r_flush),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_pipe_ctrl;

   localparam logic [31:0] PC_INIT = 32'hBFC00000;
   localparam logic [31:0] TGT_A   = 32'hBFC00380;
   localparam logic [31:0] TGT_B   = 32'h80000180;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_if, req_id, req_exe, req_mem;
   logic        exc_valid;
   logic [31:0] exc_target;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic        m_flush_now;   // flush output high in the current cycle
   logic [31:0] m_flush_pc;
   logic        m_pending;     // exception accepted, waiting for buses to go idle
   logic [31:0] m_target;
   logic [31:0] m_stall_cnt;
   logic [15:0] m_flush_cnt;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .cpu_clk_50M  (clk),
      .cpu_rst_n    (rst_n),
      .stallreq_if  (req_if),
      .stallreq_id  (req_id),
      .stallreq_exe (req_exe),
      .stallreq_mem (req_mem),
      .exc_valid    (exc_valid),
      .exc_target   (exc_target),
      .stall        (stall),
      .flush        (flush),
      .flush_pc     (flush_pc)
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   function automatic logic [5:0] exp_stall();
      if (!rst_n)             return 6'b000000;
      if (m_flush_now)        return 6'b000000;
      if (m_pending)          return 6'b011111;
      if (exc_valid)          return 6'b011111;
      if (req_mem)            return 6'b011111;
      if (req_exe)            return 6'b001111;
      if (req_id)             return 6'b000111;
      if (req_if)             return 6'b000011;
      return 6'b000000;
   endfunction

   task automatic model_edge();
      logic [5:0] s;
      logic       idle;
      s    = exp_stall();
      idle = !req_if && !req_mem;
      if (!rst_n) begin
         m_flush_now = 1'b0;
         m_flush_pc  = PC_INIT;
         m_pending   = 1'b0;
         m_target    = PC_INIT;
         m_stall_cnt = '0;
         m_flush_cnt = '0;
      end else begin
         m_stall_cnt = m_stall_cnt + {31'd0, s[0]};
         m_flush_cnt = m_flush_cnt + {15'd0, m_flush_now};
         if (m_flush_now) begin
            m_flush_now = 1'b0;
         end else if (m_pending) begin
            if (idle) begin
               m_flush_now = 1'b1;
               m_flush_pc  = m_target;
               m_pending   = 1'b0;
            end
         end else if (exc_valid) begin
            m_target = exc_target;
            if (idle) begin
               m_flush_now = 1'b1;
               m_flush_pc  = exc_target;
            end else begin
               m_pending = 1'b1;
            end
         end
      end
   endtask

   // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
   task automatic cycle(input string tag);
      logic [5:0] es;
      @(negedge clk);
      es = exp_stall();
      checks++;
      if (stall !== es) begin
         errors++;
         $display("FAIL %s stall got %b expected %b", tag, stall, es);
      end
      checks++;
      if (flush !== m_flush_now) begin
         errors++;
         $display("FAIL %s flush got %b expected %b", tag, flush, m_flush_now);
      end
      checks++;
      if (flush_pc !== m_flush_pc) begin
         errors++;
         $display("FAIL %s flush_pc got %h expected %h", tag, flush_pc, m_flush_pc);
      end
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (stall_cycles !== m_stall_cnt) begin
         errors++;
         $display("FAIL %s stall_cycles got %0d expected %0d", tag, stall_cycles, m_stall_cnt);
      end
      checks++;
      if (flush_count !== m_flush_cnt) begin
         errors++;
         $display("FAIL %s flush_count got %0d expected %0d", tag, flush_count, m_flush_cnt);
      end
`endif
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_req(input logic i_f, input logic i_d, input logic i_e, input logic i_m);
      req_if  = i_f;
      req_id  = i_d;
      req_exe = i_e;
      req_mem = i_m;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exc_valid = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      cycle("reset_pulse");
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      exc_valid = 1'b1;
      exc_target = TGT_B;
      set_req(1'b1, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      model_edge();
      #1;
      cycle("reset_hold_a");
      cycle("reset_hold_b");
      checks++;
      if (flush_pc !== PC_INIT || flush !== 1'b0) begin
         errors++;
         $display("FAIL reset_values flush=%b flush_pc=%h expected 0 %h", flush, flush_pc, PC_INIT);
      end
      exc_valid = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cycle("reset_release");
   endtask

   task automatic test_priority();
      set_req(1'b0, 1'b1, 1'b0, 1'b1);
      cycle("prio_id_mem");
      set_req(1'b0, 1'b1, 1'b0, 1'b0);
      cycle("prio_id");
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      cycle("prio_none");
      set_req(1'b1, 1'b1, 1'b1, 1'b0);
      cycle("prio_exe");
      set_req(1'b1, 1'b0, 1'b0, 1'b0);
      cycle("prio_if");
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_idle_exc();
      exc_valid  = 1'b1;
      exc_target = TGT_A;
      cycle("idle_exc_take");
      // Flush cycle: requests and a new exception must not stall or re-trigger.
      exc_target = TGT_B;
      set_req(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (flush !== 1'b1 || flush_pc !== TGT_A) begin
         errors++;
         $display("FAIL idle_exc_flush flush=%b flush_pc=%h expected 1 %h", flush, flush_pc, TGT_A);
      end
      cycle("idle_exc_flush");
      exc_valid = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL idle_exc_after flush=%b expected 0", flush);
      end
      cycle("idle_exc_after");
      cycle("idle_exc_quiet");
   endtask

   task automatic test_pending_exc();
      set_req(1'b0, 1'b0, 1'b0, 1'b1);
      exc_valid  = 1'b1;
      exc_target = TGT_A;
      cycle("pend_take");
      exc_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle("pend_wait");
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      cycle("pend_bus_drop");
      checks++;
      if (flush !== 1'b1 || flush_pc !== TGT_A) begin
         errors++;
         $display("FAIL pend_flush flush=%b flush_pc=%h expected 1 %h", flush, flush_pc, TGT_A);
      end
      cycle("pend_flush");
      cycle("pend_after");
   endtask

   task automatic test_second_exc();
      set_req(1'b1, 1'b0, 1'b0, 1'b0);
      exc_valid  = 1'b1;
      exc_target = TGT_A;
      cycle("second_first");
      exc_target = TGT_B;
      cycle("second_ignored");
      exc_valid = 1'b0;
      cycle("second_wait");
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      cycle("second_drop");
      checks++;
      if (flush_pc !== TGT_A) begin
         errors++;
         $display("FAIL second_exc_pc flush_pc=%h expected %h", flush_pc, TGT_A);
      end
      cycle("second_flush");
      cycle("second_after");
   endtask

   task automatic test_reset_mid();
      set_req(1'b0, 1'b0, 1'b0, 1'b1);
      exc_valid  = 1'b1;
      exc_target = TGT_B;
      cycle("rstmid_take");
      exc_valid = 1'b0;
      cycle("rstmid_pend");
      rst_n = 1'b0;
      cycle("rstmid_reset");
      rst_n = 1'b1;
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (flush !== 1'b0 || flush_pc !== PC_INIT || stall !== 6'b000000) begin
            errors++;
            $display("FAIL rstmid_after flush=%b flush_pc=%h stall=%b expected 0 %h 000000",
                     flush, flush_pc, stall, PC_INIT);
         end
         cycle("rstmid_after");
      end
   endtask

`ifdef PIPE_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      set_req(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle("perf_if");
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      exc_valid  = 1'b1;
      exc_target = TGT_A;
      cycle("perf_exc");
      exc_valid = 1'b0;
      cycle("perf_flush");
      // 5 IF-stall cycles plus the exception-capture cycle; one flush.
      checks++;
      if (stall_cycles !== 32'd6 || flush_count !== 16'd1) begin
         errors++;
         $display("FAIL perf_counts stall_cycles=%0d flush_count=%0d expected 6 1",
                  stall_cycles, flush_count);
      end
      cycle("perf_after");
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         req_if     = ($urandom_range(0, 2) == 0);
         req_id     = ($urandom_range(0, 3) == 0);
         req_exe    = ($urandom_range(0, 3) == 0);
         req_mem    = ($urandom_range(0, 2) == 0);
         exc_valid  = ($urandom_range(0, 5) == 0);
         exc_target = $urandom;
         rst_n      = ($urandom_range(0, 79) != 0);
         cycle("random");
      end
      rst_n     = 1'b1;
      exc_valid = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle("random_drain");
   endtask

   initial begin
      m_flush_now = 1'b0;
      m_flush_pc  = PC_INIT;
      m_pending   = 1'b0;
      m_target    = PC_INIT;
      m_stall_cnt = '0;
      m_flush_cnt = '0;
      rst_n       = 1'b0;
      exc_valid   = 1'b0;
      exc_target  = '0;
      set_req(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      test_reset();
      test_priority();
      test_idle_exc();
      test_pending_exc();
      test_second_exc();
      test_reset_mid();
`ifdef PIPE_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock and a synchronous, active-low reset: cpu_clk_50M in 1 (all state on its rising edge) and cpu_rst_n in 1 (reset is active when the input is 0 and is sampled only on the clock edge).
REQ-002 stallreq_if  in  1  instruction-bus fetch in flight/waiting.
REQ-003 stallreq_id  in  1  load-use hazard from ID.
REQ-004 stallreq_exe  in  1  multi-cycle EXE op (divider) busy.
REQ-005 stallreq_mem  in  1  data-bus access in flight/waiting.
REQ-006 exc_valid  in  1  exception or eret committed in MEM.
REQ-007 exc_target  in  32 (`INST_ADDR_BUS)  handler address or EPC for the flush.
REQ-008 stall  out  6 (`STALL_BUS)  per-stage hold; bit0 PC, bit1 IF, bit2 ID, bit3 EXE, bit4 MEM, bit5 WB; 1 = `STOP.
REQ-009 flush  out  1  clear all pipeline registers (`FLUSH = 1).
REQ-010 flush_pc  out  32  redirect PC, valid while flush=1.

Function
REQ-011 FSM states SHALL be RUN, PEND and FLUSH.
REQ-012 RUN with exc_valid=0: stall SHALL be combinational from the highest-priority request: mem 6'b011111, exe 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-013 RUN with exc_valid=1 and stallreq_if=0 and stallreq_mem=0: SHALL latch exc_target, drive stall=6'b011111 that cycle, and move to FLUSH.
REQ-014 RUN with exc_valid=1 and (stallreq_if or stallreq_mem) high: SHALL latch exc_target, drive stall=6'b011111, and move to PEND; in-flight bus transactions are never aborted.
REQ-015 PEND: stall SHALL stay 6'b011111; exc_valid SHALL be ignored (first exception wins); when stallreq_if=0 and stallreq_mem=0 in the same cycle, the state SHALL move to FLUSH.
REQ-016 FLUSH: flush=1 and flush_pc=latched target, both registered, for exactly one cycle; stall=6'b000000; the state then SHALL return to RUN unconditionally; exc_valid in this cycle SHALL be ignored.
REQ-017 Flush latency SHALL be 1 cycle after exc_valid is sampled with the buses idle; otherwise 1 cycle after the last bus request drops.
REQ-018 flush SHALL never be high in two consecutive cycles.
REQ-019 Outside FLUSH, flush SHALL be 0 and flush_pc SHALL hold its last value.

Reset
REQ-020 While cpu_rst_n=0 at a clock edge: state=RUN, flush=0, flush_pc=`PC_INIT, latched target=`PC_INIT.
REQ-021 stall SHALL be forced to 6'b000000 while cpu_rst_n=0.
REQ-022 Reset asserted in PEND or FLUSH SHALL discard the pending exception; no flush SHALL follow the reset.

Configuration
REQ-023 With PIPE_PERF_CNT_EN defined, the block SHALL add these outputs: stall_cycles out 32 (increments each cycle stall[0]=1, wraps at 2^32) and flush_count out 16 (increments each cycle flush=1, wraps); both reset to 0.
REQ-024 Without PIPE_PERF_CNT_EN, those ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-025 STALL_BUS, STOP/NOSTOP, FLUSH, PC_INIT, INST_ADDR_BUS and the FSM state encodings SHALL reside in defines.v.
REQ-026 The counters SHALL be one sub-module, pipe_perf_cnt, instantiated only under PIPE_PERF_CNT_EN; no other sub-modules.

Verification
REQ-027 Priority: stallreq_id=1 and stallreq_mem=1 together -> stall=6'b011111; drop mem -> stall=6'b000111; drop id -> 6'b000000.
REQ-028 Idle exception: exc_valid=1, exc_target=32'hBFC00380, buses idle -> next cycle flush=1, flush_pc=32'hBFC00380, stall=0; following cycle flush=0.
REQ-029 Pending exception: exc_valid=1 while stallreq_mem=1 for 3 more cycles -> stall=6'b011111 for those cycles, flush=1 exactly one cycle after stallreq_mem falls.
REQ-030 Second exception: a second exc_valid (target 32'h80000180) during PEND -> flush_pc equals the first target only.
REQ-031 Reset mid-operation: cpu_rst_n=0 during PEND -> no flush after release, stall=0, flush_pc=`PC_INIT.
REQ-032 Perf counters (PIPE_PERF_CNT_EN defined): 5 cycles of stallreq_if then one flush -> stall_cycles=5 (plus any flush-capture cycles), flush_count=1.
